// File: rtl/imu_pkg.sv
// Shared IMU types: the reader's sample record, the tilt classification and filter defaults.
package imu_pkg;

  typedef struct packed {
    logic signed [15:0] pitch;
    logic signed [15:0] roll;
    logic signed [15:0] yaw;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } data_t;

  typedef enum logic [2:0] {
    TiltLevel = 3'd0,
    TiltLeft  = 3'd1,
    TiltRight = 3'd2,
    TiltFwd   = 3'd3,
    TiltBack  = 3'd4
  } tilt_t;

  localparam int          DefThresh   = 4000;
  localparam int          DefHyst     = 1000;
  localparam int unsigned DefDebounce = 3;

  // Magnitude of a 16-bit sample; -32768 clamps so the result stays in 16-bit range.
  function automatic int abs_sat16(int v);
    if (v < -32767) return 32767;
    if (v < 0) return -v;
    return v;
  endfunction

endpackage

// File: rtl/moving_avg.sv
// Single-axis sliding-window average: ring buffer plus running sum, two-stage pipeline.
module moving_avg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LOG2  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  output logic signed [WIDTH-1:0] avg,
  output logic                    avg_valid
);

  localparam int unsigned Depth = 1 << LOG2;
  localparam int unsigned SumW  = WIDTH + LOG2;
  localparam logic [LOG2:0] FillFull = {1'b1, {LOG2{1'b0}}};

  logic signed [WIDTH-1:0] ring_q [Depth];
  logic [LOG2-1:0]         wr_ptr_q;
  logic [LOG2:0]           fill_q;
  logic signed [SumW-1:0]  sum_q;
  logic                    s1_valid_q;

  logic signed [WIDTH-1:0] oldest;
  logic signed [SumW-1:0]  new_ext;
  logic signed [SumW-1:0]  old_ext;
  logic signed [SumW-1:0]  sum_d;

  // The slot about to be overwritten holds the sample leaving the window.
  assign oldest  = ring_q[wr_ptr_q];
  assign new_ext = {{LOG2{in_data[WIDTH-1]}}, in_data};
  assign old_ext = {{LOG2{oldest[WIDTH-1]}}, oldest};
  assign sum_d   = sum_q + new_ext - old_ext;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        ring_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      s1_valid_q <= 1'b0;
      avg        <= '0;
      avg_valid  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      avg_valid  <= 1'b0;
      if (in_valid) begin
        ring_q[wr_ptr_q] <= in_data;
        wr_ptr_q         <= wr_ptr_q + LOG2'(1);
        sum_q            <= sum_d;
        if (fill_q != FillFull) begin
          fill_q <= fill_q + (LOG2 + 1)'(1);
        end
      end
      if (s1_valid_q) begin
        avg       <= WIDTH'(sum_q >>> LOG2);
        avg_valid <= (fill_q == FillFull);
      end
    end
  end

endmodule

// File: rtl/imu_tilt_filter.sv
// Averages accel X/Y over a sliding window and classifies the result into a debounced,
// hysteretic tilt direction.
module imu_tilt_filter
  import imu_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 3,
  parameter int          THRESH   = DefThresh,
  parameter int          HYST     = DefHyst,
  parameter int unsigned DEBOUNCE = DefDebounce
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [95:0] imu_data,
  output logic [15:0] avg_x,
  output logic [15:0] avg_y,
  output logic        avg_valid,
  output logic [2:0]  tilt,
  output logic        tilt_changed
);

  localparam int ExitLvl = THRESH - HYST;

  data_t       sample;
  logic        y_valid;
  logic        unused_fields;

  tilt_t       tilt_q;
  tilt_t       prev_cand_q;
  logic [31:0] deb_cnt_q;

  int          ax;
  int          ay;
  int          abs_x;
  int          abs_y;
  logic        hold;
  tilt_t       cand;
  logic [31:0] deb_next;

  assign sample = imu_data;

  moving_avg #(
    .WIDTH (16),
    .LOG2  (AVG_LOG2)
  ) u_avg_x (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sample_valid),
    .in_data   (sample.x),
    .avg       (avg_x),
    .avg_valid (avg_valid)
  );

  moving_avg #(
    .WIDTH (16),
    .LOG2  (AVG_LOG2)
  ) u_avg_y (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (sample_valid),
    .in_data   (sample.y),
    .avg       (avg_y),
    .avg_valid (y_valid)
  );

  // Both axes share one strobe, so the y copy of avg_valid is redundant.
  assign unused_fields = ^{sample.pitch, sample.roll, sample.yaw, sample.z, y_valid};

  assign ax = int'($signed(avg_x));
  assign ay = int'($signed(avg_y));

  always_comb begin
    abs_x = abs_sat16(ax);
    abs_y = abs_sat16(ay);
    hold  = 1'b0;
    cand  = TiltLevel;
    unique case (tilt_q)
      TiltRight: hold = (ax > ExitLvl);
      TiltLeft:  hold = (ax < -ExitLvl);
      TiltFwd:   hold = (ay > ExitLvl);
      TiltBack:  hold = (ay < -ExitLvl);
      default:   hold = 1'b0;
    endcase
    if (hold) begin
      cand = tilt_q;
    end else if (abs_x >= abs_y) begin
      if (ax > THRESH) cand = TiltRight;
      else if (ax < -THRESH) cand = TiltLeft;
    end else begin
      if (ay > THRESH) cand = TiltFwd;
      else if (ay < -THRESH) cand = TiltBack;
    end
  end

  assign deb_next = (cand == prev_cand_q) ? deb_cnt_q + 32'd1 : 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tilt_q       <= TiltLevel;
      prev_cand_q  <= TiltLevel;
      deb_cnt_q    <= '0;
      tilt_changed <= 1'b0;
    end else begin
      tilt_changed <= 1'b0;
      if (avg_valid) begin
        prev_cand_q <= cand;
        if (cand == tilt_q) begin
          deb_cnt_q <= '0;
        end else if (deb_next >= DEBOUNCE) begin
          tilt_q       <= cand;
          tilt_changed <= 1'b1;
          deb_cnt_q    <= '0;
        end else begin
          deb_cnt_q <= deb_next;
        end
      end
    end
  end

  assign tilt = tilt_q;

endmodule

// File: tb/tb_imu_tilt_filter.sv
// Directed-vector bench for imu_tilt_filter: window fill, averaging, hysteresis and debounce.
module tb_imu_tilt_filter;

  localparam logic [2:0] L  = 3'd0;
  localparam logic [2:0] LF = 3'd1;
  localparam logic [2:0] R  = 3'd2;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic [95:0] imu_data;
  logic [15:0] avg_x;
  logic [15:0] avg_y;
  logic        avg_valid;
  logic [2:0]  tilt;
  logic        tilt_changed;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         rst;
    int         x;
    int         y;
    bit         v;
    int         ax;
    int         ay;
    logic [2:0] t;
    bit         c;
  } vec_t;

  vec_t vecs[$];

  imu_tilt_filter dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .imu_data     (imu_data),
    .avg_x        (avg_x),
    .avg_y        (avg_y),
    .avg_valid    (avg_valid),
    .tilt         (tilt),
    .tilt_changed (tilt_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [95:0] pack(int x, int y);
    return {16'h1111, 16'h2222, 16'h3333, 16'(x), 16'(y), 16'h4444};
  endfunction

  function automatic void add(bit rst, int x, int y, bit v, int ax, int ay, logic [2:0] t,
                              bit c);
    vec_t r;
    r.rst = rst; r.x = x; r.y = y; r.v = v; r.ax = ax; r.ay = ay; r.t = t; r.c = c;
    vecs.push_back(r);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sample_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, " avg_x"}, int'($signed(avg_x)), 0);
    chk({tag, " avg_y"}, int'($signed(avg_y)), 0);
    chk({tag, " avg_valid"}, int'(avg_valid), 0);
    chk({tag, " tilt"}, int'(tilt), int'(L));
    chk({tag, " tilt_changed"}, int'(tilt_changed), 0);
  endtask

  initial begin
    int pulses;
    reset = 1'b0;
    sample_valid = 1'b0;
    imu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;

    // Fill with x=1000: partial averages, first valid on 8th sample
    for (int k = 1; k <= 7; k++) add(0, 1000, 0, 0, 125 * k, 0, L, 0);
    add(0, 1000, 0, 1, 1000, 0, L, 0);
    // Drain to zero
    add(0, 0, 0, 1, 875, 0, L, 0);  add(0, 0, 0, 1, 750, 0, L, 0);
    add(0, 0, 0, 1, 625, 0, L, 0);  add(0, 0, 0, 1, 500, 0, L, 0);
    add(0, 0, 0, 1, 375, 0, L, 0);  add(0, 0, 0, 1, 250, 0, L, 0);
    add(0, 0, 0, 1, 125, 0, L, 0);  add(0, 0, 0, 1, 0, 0, L, 0);
    // Step to 8000: 4000 is not beyond threshold, RIGHT on 3rd candidate
    add(0, 8000, 0, 1, 1000, 0, L, 0); add(0, 8000, 0, 1, 2000, 0, L, 0);
    add(0, 8000, 0, 1, 3000, 0, L, 0); add(0, 8000, 0, 1, 4000, 0, L, 0);
    add(0, 8000, 0, 1, 5000, 0, L, 0); add(0, 8000, 0, 1, 6000, 0, L, 0);
    add(0, 8000, 0, 1, 7000, 0, R, 1); add(0, 8000, 0, 1, 8000, 0, R, 0);
    // Toward 3500 after pointer wrap: hold keeps RIGHT
    add(0, 3500, 0, 1, 7437, 0, R, 0); add(0, 3500, 0, 1, 6875, 0, R, 0);
    add(0, 3500, 0, 1, 6312, 0, R, 0); add(0, 3500, 0, 1, 5750, 0, R, 0);
    add(0, 3500, 0, 1, 5187, 0, R, 0); add(0, 3500, 0, 1, 4625, 0, R, 0);
    add(0, 3500, 0, 1, 4062, 0, R, 0); add(0, 3500, 0, 1, 3500, 0, R, 0);
    // Toward 2500: exit once avg reaches 3000, LEVEL three valids later
    add(0, 2500, 0, 1, 3375, 0, R, 0); add(0, 2500, 0, 1, 3250, 0, R, 0);
    add(0, 2500, 0, 1, 3125, 0, R, 0); add(0, 2500, 0, 1, 3000, 0, R, 0);
    add(0, 2500, 0, 1, 2875, 0, R, 0); add(0, 2500, 0, 1, 2750, 0, L, 1);
    add(0, 2500, 0, 1, 2625, 0, L, 0); add(0, 2500, 0, 1, 2500, 0, L, 0);
    // Alternating RIGHT/FWD candidates never settle; two agreeing RIGHTs then do
    add(1, -20000, 0, 0, -2500, 0, L, 0);      add(0, 20000, -20000, 0, 0, -2500, L, 0);
    add(0, -20000, 20000, 0, -2500, 0, L, 0);  add(0, 20000, -20000, 0, 0, -2500, L, 0);
    add(0, -20000, 20000, 0, -2500, 0, L, 0);  add(0, 20000, 0, 0, 0, 0, L, 0);
    add(0, 0, 0, 0, 0, 0, L, 0);               add(0, 0, 0, 1, 0, 0, L, 0);
    add(0, 20000, 0, 1, 5000, 0, L, 0);        add(0, -20000, 20000, 1, 0, 5000, L, 0);
    add(0, 20000, -20000, 1, 5000, 0, L, 0);   add(0, -20000, 20000, 1, 0, 5000, L, 0);
    add(0, 20000, -20000, 1, 5000, 0, L, 0);   add(0, 20000, 0, 1, 5000, 0, L, 0);
    add(0, 0, 0, 1, 5000, 0, R, 1);
    // Tie |x| == |y|: x wins
    for (int k = 1; k <= 7; k++) add(k == 1, 5000, -5000, 0, 625 * k, -625 * k, L, 0);
    add(0, 5000, -5000, 1, 5000, -5000, L, 0);
    add(0, 5000, -5000, 1, 5000, -5000, L, 0);
    add(0, 5000, -5000, 1, 5000, -5000, R, 1);
    // Floor of -1/8 and full-scale negative
    for (int k = 1; k <= 7; k++) add(k == 1, 0, 0, 0, 0, 0, L, 0);
    add(0, -1, 0, 1, -1, 0, L, 0);
    add(0, -32768, 0, 1, -4097, 0, L, 0);   add(0, -32768, 0, 1, -8193, 0, L, 0);
    add(0, -32768, 0, 1, -12289, 0, LF, 1); add(0, -32768, 0, 1, -16385, 0, LF, 0);
    add(0, -32768, 0, 1, -20481, 0, LF, 0); add(0, -32768, 0, 1, -24577, 0, LF, 0);
    add(0, -32768, 0, 1, -28673, 0, LF, 0); add(0, -32768, 0, 1, -32768, 0, LF, 0);
    add(0, -32768, 0, 1, -32768, 0, LF, 0); add(0, -32768, 0, 1, -32768, 0, LF, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      sample_valid = 1'b1;
      imu_data = pack(vecs[i].x, vecs[i].y);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("row%0d avg_valid", i), int'(avg_valid), int'(vecs[i].v));
      chk($sformatf("row%0d avg_x", i), int'($signed(avg_x)), vecs[i].ax);
      chk($sformatf("row%0d avg_y", i), int'($signed(avg_y)), vecs[i].ay);
      @(posedge clk); #1;
      chk($sformatf("row%0d tilt", i), int'(tilt), int'(vecs[i].t));
      chk($sformatf("row%0d tilt_changed", i), int'(tilt_changed), int'(vecs[i].c));
    end

    // Back-to-back: 20 samples give 13 pulses, each two cycles after its sample
    do_reset();
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      sample_valid = (c < 20);
      imu_data = pack(1000, 0);
      chk($sformatf("b2b c%0d avg_valid", c), int'(avg_valid), int'(c >= 9 && c <= 21));
      if (avg_valid) begin
        pulses++;
        chk($sformatf("b2b c%0d avg_x", c), int'($signed(avg_x)), 1000);
      end
      @(posedge clk); #1;
    end
    chk("b2b pulse count", pulses, 13);

    // Reset mid-fill with a sample presented during reset
    for (int c = 0; c < 3; c++) begin
      sample_valid = 1'b1;
      imu_data = pack(8000, 3000);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sample_valid = 1'b0;
    chk_idle("midreset");
    @(posedge clk); #1;
    chk("midreset+1 avg_valid", int'(avg_valid), 0);
    for (int c = 0; c < 11; c++) begin
      sample_valid = (c < 8);
      imu_data = pack(1000, 0);
      chk($sformatf("refill c%0d avg_valid", c), int'(avg_valid), int'(c == 9));
      if (c == 9) chk("refill avg_x", int'($signed(avg_x)), 1000);
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imu_tilt_filter.md
# imu_tilt_filter

Downstream consumer of the IMU reader's `data_t` sample stream. It keeps a sliding-window moving average of the accelerometer X/Y fields and classifies the averaged vector into a debounced, hysteretic tilt direction for game/display logic. It sits between the IMU SPI reader and the application FSM. Gyro and Z fields pass through unused.

## Interface
- `AVG_LOG2`, 3: window depth is 2^AVG_LOG2 samples (1..5 supported).
- `THRESH`, 4000: signed entry threshold on averaged accel magnitude.
- `HYST`, 1000: hysteresis; exit threshold is THRESH−HYST.
- `DEBOUNCE`, 3: consecutive differing classifications required before `tilt` changes.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-low reset.
- `sample_valid`  in  1  one-cycle strobe: `imu_data` holds a new sample this cycle.
- `imu_data`  in  96  `data_t` (pitch, roll, yaw, x, y, z; 16-bit two's complement each).
- `avg_x`, `avg_y`  out  16  signed window averages.
- `avg_valid`  out  1  one-cycle pulse: new averages are on `avg_x`/`avg_y`.
- `tilt`  out  3  `tilt_t`: LEVEL=0, LEFT=1, RIGHT=2, FWD=3, BACK=4.
- `tilt_changed`  out  1  one-cycle pulse when `tilt` updates.

## Operation
- Reset (`reset`=0 at a clock edge):
  - zero ring buffers, sums, fill count and write pointer;
  - `avg_x`=`avg_y`=0, `avg_valid`=0, `tilt`=LEVEL, `tilt_changed`=0, debounce count 0.
  - `sample_valid` is ignored while in reset.
  - Reset mid-fill or mid-debounce discards all history.
- Stage 1, on each accepted `sample_valid`:
  - Read the oldest entry at `wr_ptr` before overwriting it with the new x/y.
  - `sum <= sum + new − oldest`, per axis.
  - Sums are signed 16+AVG_LOG2 bits; they cannot overflow.
  - `wr_ptr` wraps modulo 2^AVG_LOG2.
  - Fill count saturates at 2^AVG_LOG2.
- Stage 2: `avg = sum >>> AVG_LOG2` (arithmetic shift, rounds toward −inf).
  - Registered every sample.
  - `avg_valid` pulses only once the fill count is full, i.e. from the 2^AVG_LOG2-th sample onward.
- Classification, on each `avg_valid`:
  - `|v|` saturates: |−32768| = 32767.
  - Hold rule: if `tilt`≠LEVEL and its own axis is still beyond THRESH−HYST in its sign (e.g. RIGHT: avg_x > THRESH−HYST), the candidate is the current `tilt`.
  - Otherwise the dominant axis is x if |avg_x| ≥ |avg_y| (ties go to x), else y.
  - Dominant x: > THRESH gives RIGHT, < −THRESH gives LEFT.
  - Dominant y: > THRESH gives FWD, < −THRESH gives BACK.
  - Anything else gives LEVEL.
- Debounce:
  - Candidate == `tilt`: counter clears.
  - Candidate ≠ `tilt` and equal to the previous candidate: counter increments; otherwise counter restarts at 1.
  - Counter reaches DEBOUNCE: `tilt` ← candidate, `tilt_changed` pulses, counter clears.
- Tilt FSM states are LEVEL, LEFT, RIGHT, FWD, BACK. Transitions are only as above; any state may reach any other directly.

## Timing
- `sample_valid` is high in cycle t:
  - buffer and sums update at the t+1 edge;
  - `avg_*` and `avg_valid` are high during cycle t+2;
  - `tilt` and `tilt_changed` update during cycle t+3.
- Fully pipelined: `sample_valid` may be asserted every cycle with no loss. Back-to-back samples into the same buffer slot after a wrap are read-before-write correct.
- All outputs are registered. The pulses are exactly one cycle wide.

## Structure
- The `data_t` typedef moves into shared package `imu_pkg`, together with the new `tilt_t` enum and default constants (THRESH, HYST, DEBOUNCE). The IMU reader imports the same package.
- One natural sub-module: `moving_avg #(WIDTH, LOG2)`, a single-axis ring buffer plus accumulator, instantiated for x and y. Classification and debounce stay in the top.

## Test plan
- After reset, feed 7 samples with x=1000 → no `avg_valid`. The 8th sample → `avg_valid` at t+2 with `avg_x`=1000.
- Window full of x=0, then one x=8000 → `avg_x`=1000. Seven more → `avg_x`=8000. Further samples confirm `wr_ptr` wrap.
- Seven x=0 then one x=−1 → `avg_x`=−1 (floor). All x=−32768 → `avg_x`=−32768; classification gives LEFT without abs overflow.
- Sustained avg_x=5000, avg_y=0 → `tilt`=RIGHT with one `tilt_changed` pulse on the 3rd `avg_valid`.
  - Then avg_x=3500 → stays RIGHT (hold, exit at 3000).
  - Then avg_x=2500 → LEVEL after 3 avg_valids.
  - Alternating candidates RIGHT/FWD never change `tilt`.
- Tie: avg_x=5000, avg_y=−5000 from LEVEL → RIGHT (x wins).
- `sample_valid` every cycle for 20 cycles → 13 `avg_valid` pulses, each at t+2.
  - Assert `reset`=0 mid-fill → all outputs 0 / LEVEL next cycle.
  - Afterwards, 8 fresh samples are needed before the next `avg_valid`.
